// File: rtl/kem_seed_sequencer_pkg.sv
// Shared types and constants for the KEM seed sequencer.
package TYPES_KEM;

    localparam int KEM_SEED_W = 256;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DATA = 3'd2,
        GAP       = 3'd3,
        DONE      = 3'd4
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/kem_seed_sequencer_down_counter.sv
// Loadable down counter with a zero flag; saturates at zero.
module kem_seq_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over decrement; decrementing stops at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (dec_i && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero_o = (r_count == '0);

endmodule

// File: rtl/kem_seed_sequencer.sv
// KEM seed sequencer: fetches a programmable number of TRNG seeds into a slot bank.
// Optional WAIT_DATA timeout is enabled by defining KEM_SEQ_TIMEOUT_EN.
module kem_seed_sequencer
    import TYPES_KEM::*;
#(
    parameter int NUM_SEEDS      = 2,
    parameter int SEED_W         = KEM_SEED_W,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CNT_W         = $clog2(NUM_SEEDS + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [CNT_W-1:0]            count_i,
    input  logic                        abort_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        trng_run_o,
    input  logic                        trng_dvld_i,
    input  logic [SEED_W-1:0]           trng_dout_i,
    output logic [NUM_SEEDS*SEED_W-1:0] seed_o,
    output logic [NUM_SEEDS-1:0]        seed_vld_o
`ifdef KEM_SEQ_TIMEOUT_EN
    ,
    output logic                        timeout_o
`endif
);

    // The counter's zero flag marks the last cycle of a wait, so loads are one less
    // than the number of cycles to stay.
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int TO_LOAD  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int TMR_MAX  = max_int(GAP_LOAD, TO_LOAD);
    localparam int TMR_W    = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_SEEDS);

    seq_state_t                  r_state;
    seq_state_t                  w_next;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            r_idx;
    logic [NUM_SEEDS*SEED_W-1:0] r_seed;
    logic [NUM_SEEDS-1:0]        r_vld;
    logic [CNT_W-1:0]            w_clamped;
    logic                        w_accept;
    logic                        w_capture;
    logic                        w_last;
    logic                        w_tmr_load;
    logic [TMR_W-1:0]            w_tmr_val;
    logic                        w_tmr_dec;
    logic                        w_tmr_zero;
    logic                        w_timeout;

    assign w_clamped = (count_i > MAX_CNT) ? MAX_CNT : count_i;
    assign w_accept  = (r_state == IDLE) && start_i && !abort_i;
    assign w_capture = (r_state == WAIT_DATA) && trng_dvld_i && !abort_i;
    assign w_last    = (r_idx == (r_cnt - CNT_W'(1)));

    // One timer serves both the inter-request gap and the data timeout; they never overlap.
    kem_seq_down_counter #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .dec_i      (w_tmr_dec),
        .zero_o     (w_tmr_zero)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and timer control; abort overrides everything.
    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_dec  = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next = (w_clamped == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                w_next = WAIT_DATA;
`ifdef KEM_SEQ_TIMEOUT_EN
                w_tmr_load = 1'b1;
                w_tmr_val  = TMR_W'(TO_LOAD);
`endif
            end
            WAIT_DATA: begin
                if (trng_dvld_i) begin
                    if (w_last) begin
                        w_next = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        w_next = REQ;
                    end else begin
                        w_next     = GAP;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = TMR_W'(GAP_LOAD);
                    end
                end
`ifdef KEM_SEQ_TIMEOUT_EN
                else if (w_tmr_zero) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
`endif
            end
            GAP: begin
                if (w_tmr_zero) begin
                    w_next = REQ;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (abort_i) begin
            w_next     = IDLE;
            w_tmr_load = 1'b0;
            w_timeout  = 1'b0;
        end
    end

    // Run setup on an accepted start, and slot capture on each TRNG response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_seed <= '0;
            r_vld  <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= w_clamped;
                r_idx <= '0;
                r_vld <= '0;
            end
            if (w_capture) begin
                for (int k = 0; k < NUM_SEEDS; k++) begin
                    if (r_idx == CNT_W'(k)) begin
                        r_seed[k*SEED_W +: SEED_W] <= trng_dout_i;
                        r_vld[k]                   <= 1'b1;
                    end
                end
                if (!w_last) begin
                    r_idx <= r_idx + CNT_W'(1);
                end
            end
        end
    end

`ifdef KEM_SEQ_TIMEOUT_EN
    logic r_timeout;

    // Timeout pulse is registered so it coincides with the return to IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
        end
    end

    assign timeout_o = r_timeout;
`endif

    assign busy_o     = (r_state != IDLE);
    assign done_o     = (r_state == DONE);
    assign trng_run_o = (r_state == REQ);
    assign seed_o     = r_seed;
    assign seed_vld_o = r_vld;

endmodule

// File: tb/tb_kem_seed_sequencer.sv
// Scoreboard testbench for kem_seed_sequencer (NUM_SEEDS=3, GAP_CYCLES=1, 5-cycle TRNG).
module tb_kem_seed_sequencer;

    localparam int NS          = 3;
    localparam int SW          = 256;
    localparam int GAPC        = 1;
    localparam int TO          = 16;
    localparam int LAT         = 5;
    localparam int CW          = 2;
    localparam int RUN_SPACING = 7;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [CW-1:0]     count_i;
    logic              abort_i;
    logic              busy_o;
    logic              done_o;
    logic              trng_run_o;
    logic              trng_dvld_i;
    logic [SW-1:0]     trng_dout_i;
    logic [NS*SW-1:0]  seed_o;
    logic [NS-1:0]     seed_vld_o;
`ifdef KEM_SEQ_TIMEOUT_EN
    logic              timeout_o;
`endif

    typedef struct {
        logic [2:0]    vld;
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;
        logic [SW-1:0] s2;
        int            runs;
    } exp_t;

    exp_t          sbQ[$];
    logic [SW-1:0] trngData[$];
    int            nChecks     = 0;
    int            nFail       = 0;
    int            cyc         = 0;
    bit            trngOn      = 1'b1;
    int            respTotal   = 0;
    int            abortAt     = -1;
    int            abortCyc    = 0;
    int            lastRespCyc = 0;
    int            runCount    = 0;
    int            lastRunCyc  = 0;
    int            startCyc    = 0;

    localparam logic [SW-1:0] DAA = {32{8'hAA}};
    localparam logic [SW-1:0] D55 = {32{8'h55}};
    localparam logic [SW-1:0] D11 = {32{8'h11}};
    localparam logic [SW-1:0] D22 = {32{8'h22}};
    localparam logic [SW-1:0] D33 = {32{8'h33}};
    localparam logic [SW-1:0] D44 = {32{8'h44}};
    localparam logic [SW-1:0] D66 = {32{8'h66}};
    localparam logic [SW-1:0] D77 = {32{8'h77}};
    localparam logic [SW-1:0] D88 = {32{8'h88}};
    localparam logic [SW-1:0] D99 = {32{8'h99}};
    localparam logic [SW-1:0] DEE = {32{8'hEE}};

    kem_seed_sequencer #(
        .NUM_SEEDS      (NS),
        .SEED_W         (SW),
        .GAP_CYCLES     (GAPC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .count_i     (count_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .trng_run_o  (trng_run_o),
        .trng_dvld_i (trng_dvld_i),
        .trng_dout_i (trng_dout_i),
        .seed_o      (seed_o),
        .seed_vld_o  (seed_vld_o)
`ifdef KEM_SEQ_TIMEOUT_EN
        ,
        .timeout_o   (timeout_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t makeExp(input logic [2:0] v, input logic [SW-1:0] a,
                                     input logic [SW-1:0] b, input logic [SW-1:0] c, input int r);
        exp_t e;
        e.vld  = v;
        e.s0   = a;
        e.s1   = b;
        e.s2   = c;
        e.runs = r;
        return e;
    endfunction

    task automatic applyStimulus(input logic [CW-1:0] cnt);
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        count_i = cnt;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        count_i = '0;
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (busy_o && n < 300);
        if (busy_o) checkOutput("wait_idle_bound", 1, 0);
    endtask

    // TRNG model: answers each run pulse LAT cycles later with the next queued seed
    initial begin
        forever begin
            @(negedge clk_i);
            if (trng_run_o && trngOn && !rst_i) begin
                repeat (LAT) @(posedge clk_i);
                #1;
                respTotal++;
                trng_dvld_i = 1'b1;
                trng_dout_i = (trngData.size() > 0) ? trngData.pop_front() : '0;
                lastRespCyc = cyc;
                if (respTotal == abortAt) begin
                    abort_i  = 1'b1;
                    abortCyc = cyc;
                end
                @(posedge clk_i);
                #1;
                trng_dvld_i = 1'b0;
                abort_i     = 1'b0;
            end
        end
    end

    // Monitor: tracks run pulses and checks every done_o against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (start_i && !busy_o && !abort_i) begin
                    runCount = 0;
                    startCyc = cyc;
                end
                if (trng_run_o) begin
                    if (runCount > 0) checkOutput("run_spacing", cyc - lastRunCyc, RUN_SPACING);
                    runCount++;
                    lastRunCyc = cyc;
                end
                if (done_o) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected_done", 1, 0);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("done_vld", seed_vld_o, e.vld);
                        checkOutput("done_slot0", seed_o[0*SW +: SW], e.s0);
                        checkOutput("done_slot1", seed_o[1*SW +: SW], e.s1);
                        checkOutput("done_slot2", seed_o[2*SW +: SW], e.s2);
                        checkOutput("done_runs", runCount, e.runs);
                        if (e.runs == 0) checkOutput("done_cycle", cyc, startCyc + 1);
                        else             checkOutput("done_cycle", cyc, lastRespCyc + 1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int toCyc;
        int reqCyc;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        count_i     = '0;
        abort_i     = 1'b0;
        trng_dvld_i = 1'b0;
        trng_dout_i = '0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_run", trng_run_o, 0);
        checkOutput("rst_vld", seed_vld_o, 0);
        checkOutput("rst_seed", SW'(|seed_o), 0);
`ifdef KEM_SEQ_TIMEOUT_EN
        checkOutput("rst_timeout", timeout_o, 0);
`endif
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        $display("[TB] two seeds AA/55");
        trngData.push_back(DAA);
        trngData.push_back(D55);
        sbQ.push_back(makeExp(3'b011, DAA, D55, '0, 2));
        applyStimulus(CW'(2));
        waitIdle();

        $display("[TB] zero count");
        sbQ.push_back(makeExp(3'b000, DAA, D55, '0, 0));
        applyStimulus(CW'(0));
        waitIdle();

        $display("[TB] full bank");
        trngData.push_back(D11);
        trngData.push_back(D22);
        trngData.push_back(D33);
        sbQ.push_back(makeExp(3'b111, D11, D22, D33, 3));
        applyStimulus(CW'(7));
        waitIdle();

        $display("[TB] abort with second response");
        trngData.push_back(D44);
        trngData.push_back(D66);
        abortAt = respTotal + 2;
        applyStimulus(CW'(2));
        waitIdle();
        abortAt = -1;
        checkOutput("abort_idle_cycle", cyc, abortCyc + 1);
        checkOutput("abort_vld", seed_vld_o, 3'b001);
        checkOutput("abort_slot0", seed_o[0*SW +: SW], D44);
        checkOutput("abort_slot1", seed_o[1*SW +: SW], D22);

        $display("[TB] run after abort");
        trngData.push_back(D77);
        sbQ.push_back(makeExp(3'b001, D77, D22, D33, 1));
        applyStimulus(CW'(1));
        waitIdle();

        $display("[TB] stray start and dvld during gap");
        trngData.push_back(D88);
        trngData.push_back(D99);
        sbQ.push_back(makeExp(3'b011, D88, D99, D33, 2));
        applyStimulus(CW'(2));
        for (int n = 0; n < 50 && !seed_vld_o[0]; n++) @(negedge clk_i);
        checkOutput("gap_reached", seed_vld_o[0], 1);
        start_i     = 1'b1;
        count_i     = CW'(1);
        trng_dvld_i = 1'b1;
        trng_dout_i = DEE;
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        count_i     = '0;
        trng_dvld_i = 1'b0;
        trng_dout_i = '0;
        waitIdle();

        $display("[TB] reset during REQ and WAIT_DATA");
        trngOn = 1'b0;
        applyStimulus(CW'(1));
        checkOutput("req_run", trng_run_o, 1);
        rst_i = 1'b1;
        #1;
        checkOutput("req_rst_run", trng_run_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        applyStimulus(CW'(1));
        repeat (3) @(negedge clk_i);
        checkOutput("wait_busy", busy_o, 1);
        rst_i = 1'b1;
        #1;
        checkOutput("mid_rst_busy", busy_o, 0);
        checkOutput("mid_rst_done", done_o, 0);
        checkOutput("mid_rst_run", trng_run_o, 0);
        checkOutput("mid_rst_vld", seed_vld_o, 0);
        checkOutput("mid_rst_seed", SW'(|seed_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

`ifdef KEM_SEQ_TIMEOUT_EN
        $display("[TB] timeout with silent TRNG");
        applyStimulus(CW'(1));
        reqCyc = cyc;
        toCyc  = -1;
        for (int n = 0; n < 60 && toCyc < 0; n++) begin
            @(negedge clk_i);
            if (timeout_o) toCyc = cyc;
        end
        checkOutput("timeout_cycle", toCyc, reqCyc + 1 + TO);
        checkOutput("timeout_busy", busy_o, 0);
        checkOutput("timeout_vld", seed_vld_o, 0);
        @(negedge clk_i);
        checkOutput("timeout_single", timeout_o, 0);
`else
        toCyc  = 0;
        reqCyc = 0;
`endif
        trngOn = 1'b1;

        repeat (5) @(negedge clk_i);
        checkOutput("sb_empty", sbQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
